// File: rtl/pll_reset_sequencer.sv
// Supervises PLL reset/lock on the reference clock and sequences the system reset release.
// All outputs registered; state and outputs move together. No handshake or backpressure.
module pll_reset_sequencer #(
  parameter int PLL_RESET_CYCLES     = 16,
  parameter int LOCK_FILTER_CYCLES   = 64,
  parameter int RELEASE_DELAY_CYCLES = 256,
  parameter int RETRY_TIMEOUT_CYCLES = 65536,
  parameter int LOSS_FILTER_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       pll_ready,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  localparam int MAX_AB = (PLL_RESET_CYCLES > LOCK_FILTER_CYCLES) ? PLL_RESET_CYCLES : LOCK_FILTER_CYCLES;
  localparam int MAX_CD = (RELEASE_DELAY_CYCLES > RETRY_TIMEOUT_CYCLES) ? RELEASE_DELAY_CYCLES : RETRY_TIMEOUT_CYCLES;
  localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_ALL = (MAX_ABCD > LOSS_FILTER_CYCLES) ? MAX_ABCD : LOSS_FILTER_CYCLES;
  localparam int CW = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] RST_LAST   = CW'(PLL_RESET_CYCLES - 1);
  localparam logic [CW-1:0] FILT_LAST  = CW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST   = CW'(RELEASE_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RETRY_LAST = CW'(RETRY_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LOSS_LAST  = CW'(LOSS_FILTER_CYCLES - 1);

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    FILTER,
    HOLD,
    RUN
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   loss_cnt, loss_cnt_nxt;
  logic [7:0]      retry_nxt;
  logic            lost_nxt;
  logic            loss_hit;
  logic            lock_meta, lock_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta   <= 1'b0;
      lock_sync   <= 1'b0;
      state       <= PLL_RESET;
      cnt         <= '0;
      loss_cnt    <= '0;
      pll_resetb  <= 1'b0;
      sys_reset   <= 1'b1;
      pll_ready   <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= 8'd0;
    end else begin
      lock_meta   <= pll_lock;
      lock_sync   <= lock_meta;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      loss_cnt    <= loss_cnt_nxt;
      pll_resetb  <= (state_nxt != PLL_RESET);
      sys_reset   <= (state_nxt != RUN);
      pll_ready   <= (state_nxt == HOLD) || (state_nxt == RUN);
      lock_lost   <= lost_nxt;
      retry_count <= retry_nxt;
    end
  end

  // Qualified loss: this low cycle completes the required run of consecutive lows.
  assign loss_hit = !lock_sync && (loss_cnt == LOSS_LAST);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + CW'(1);
    loss_cnt_nxt = '0;
    retry_nxt    = retry_count;
    lost_nxt     = 1'b0;

    case (state)
      PLL_RESET: begin
        if (cnt == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        // A lock arriving on the timeout cycle takes priority over the retry.
        if (lock_sync) begin
          state_nxt = FILTER;
          cnt_nxt   = '0;
        end else if (cnt == RETRY_LAST) begin
          state_nxt = PLL_RESET;
          cnt_nxt   = '0;
          retry_nxt = (retry_count == 8'hFF) ? retry_count : retry_count + 8'd1;
        end
      end
      FILTER: begin
        if (!lock_sync) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == FILT_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        loss_cnt_nxt = lock_sync ? '0 : loss_cnt + CW'(1);
        if (loss_hit) begin
          state_nxt    = PLL_RESET;
          cnt_nxt      = '0;
          loss_cnt_nxt = '0;
          lost_nxt     = 1'b1;
        end else if (cnt == REL_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        // The main counter parks here so it can never wrap while running.
        cnt_nxt      = cnt;
        loss_cnt_nxt = lock_sync ? '0 : loss_cnt + CW'(1);
        if (loss_hit) begin
          state_nxt    = PLL_RESET;
          cnt_nxt      = '0;
          loss_cnt_nxt = '0;
          lost_nxt     = 1'b1;
        end
      end
      default: begin
        state_nxt = PLL_RESET;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
